// File: rtl/snake_body_engine.sv
// snake_body_engine: snake body controller for the Snake game DPU.
// Keeps the body as a circular buffer of cells, exports a grid occupancy
// vector and advances one cell per Step with growth, collision and win
// handling. Optional toroidal walls are enabled by defining SNAKE_WRAP_EN.
module snake_body_engine #(
  parameter int GRID_W  = 15,
  parameter int GRID_H  = 15,
  parameter int CW      = 4,
  parameter int MAX_LEN = 32,
  parameter int LW      = 8
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     Start,
  input  logic                     Step,
  input  logic [1:0]               Dir_In,
  input  logic                     Dir_Valid,
  input  logic [CW-1:0]            Apple_X,
  input  logic [CW-1:0]            Apple_Y,
  output logic [CW-1:0]            Head_X,
  output logic [CW-1:0]            Head_Y,
  output logic [CW-1:0]            Tail_X,
  output logic [CW-1:0]            Tail_Y,
  output logic [LW-1:0]            Length,
  output logic [GRID_W*GRID_H-1:0] Occupancy,
  output logic                     Ate,
  output logic                     Collision,
  output logic                     Win,
  output logic [1:0]               State
);

  localparam int NCELL = GRID_W * GRID_H;
  localparam int OW    = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam int PW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_LOST = 2'b10;
  localparam logic [1:0] ST_WON  = 2'b11;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam logic [CW:0]   ONE_EXT = (CW+1)'(1);
  localparam logic [CW:0]   GW_EXT  = (CW+1)'(GRID_W);
  localparam logic [CW:0]   GH_EXT  = (CW+1)'(GRID_H);
  localparam logic [CW-1:0] X0      = CW'(GRID_W / 2);
  localparam logic [CW-1:0] Y0      = CW'(GRID_H / 2);
  localparam logic [CW-1:0] Y0_M1   = CW'(GRID_H / 2 - 1);
  localparam logic [CW-1:0] Y0_M2   = CW'(GRID_H / 2 - 2);
  localparam logic [PW-1:0] PTR_LAST = PW'(MAX_LEN - 1);
  localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);

  // Flat occupancy index of cell (x,y).
  function automatic logic [OW-1:0] cell_idx(input logic [CW-1:0] x, input logic [CW-1:0] y);
    int t;
    t = int'(x) * GRID_H + int'(y);
    return OW'(t);
  endfunction

  function automatic logic [1:0] rev_dir(input logic [1:0] d);
    return {d[1], ~d[0]};
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  localparam logic [NCELL-1:0] OCC_INIT = (NCELL'(1) << cell_idx(X0, Y0))
                                        | (NCELL'(1) << cell_idx(X0, Y0_M1))
                                        | (NCELL'(1) << cell_idx(X0, Y0_M2));

  logic [CW-1:0]    body_x [MAX_LEN];
  logic [CW-1:0]    body_y [MAX_LEN];
  logic [PW-1:0]    head_ptr, tail_ptr, head_ptr_nx, tail_ptr_nx;
  logic [1:0]       cur_dir, pend_dir, eff_dir;
  logic [CW:0]      nx_ext, ny_ext;
  logic [CW-1:0]    nxt_x, nxt_y;
  logic [OW-1:0]    nxt_idx, tail_idx;
  logic [NCELL-1:0] occ_next;
  logic [LW-1:0]    len_plus;
  logic             run_step, reload, wall_hit, self_hit, hit, grow, hits_tail, occ_bit, dir_ok;

  assign run_step    = (State == ST_RUN) && Step;
  assign reload      = Start && ((State == ST_LOST) || (State == ST_WON));
  assign head_ptr_nx = ptr_inc(head_ptr);
  assign tail_ptr_nx = ptr_inc(tail_ptr);
  assign len_plus    = Length + LW'(1);

  // Candidate head cell at CW+1 bits: a step below 0 becomes all-ones and
  // therefore also compares as >= the grid size.
  always_comb begin
    nx_ext = {1'b0, Head_X};
    ny_ext = {1'b0, Head_Y};
    case (pend_dir)
      DIR_UP:    ny_ext = {1'b0, Head_Y} + ONE_EXT;
      DIR_DOWN:  ny_ext = {1'b0, Head_Y} - ONE_EXT;
      DIR_LEFT:  nx_ext = {1'b0, Head_X} - ONE_EXT;
      default:   nx_ext = {1'b0, Head_X} + ONE_EXT;
    endcase
  end

  // Wall handling: toroidal wrap or wall hit.
  always_comb begin
`ifdef SNAKE_WRAP_EN
    nxt_x    = (nx_ext == '1) ? CW'(GRID_W - 1) : (nx_ext == GW_EXT) ? '0 : nx_ext[CW-1:0];
    nxt_y    = (ny_ext == '1) ? CW'(GRID_H - 1) : (ny_ext == GH_EXT) ? '0 : ny_ext[CW-1:0];
    wall_hit = 1'b0;
`else
    nxt_x    = nx_ext[CW-1:0];
    nxt_y    = ny_ext[CW-1:0];
    wall_hit = (nx_ext >= GW_EXT) || (ny_ext >= GH_EXT);
`endif
  end

  // Growth and self-collision; entering a vacating tail cell is legal.
  always_comb begin
    nxt_idx   = cell_idx(nxt_x, nxt_y);
    tail_idx  = cell_idx(Tail_X, Tail_Y);
    grow      = (nxt_x == Apple_X) && (nxt_y == Apple_Y);
    hits_tail = (nxt_x == Tail_X) && (nxt_y == Tail_Y);
    occ_bit   = (int'(nxt_idx) < NCELL) ? Occupancy[nxt_idx] : 1'b0;
    self_hit  = !wall_hit && occ_bit && !(hits_tail && !grow);
    hit       = wall_hit || self_hit;
  end

  // Occupancy after a legal move: clearing the tail first lets the head
  // re-set it when it moves into the vacated cell.
  always_comb begin
    occ_next = Occupancy;
    if (!grow) occ_next[tail_idx] = 1'b0;
    occ_next[nxt_idx] = 1'b1;
  end

  // A request is dropped if it reverses the direction in effect after this
  // cycle or the one already pending, so no queued turn can fold back.
  always_comb begin
    eff_dir = run_step ? pend_dir : cur_dir;
    dir_ok  = Dir_Valid && (Dir_In != rev_dir(eff_dir)) && (Dir_In != rev_dir(pend_dir));
  end

  // Pending direction register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pend_dir <= DIR_UP;
    end else if (reload) begin
      pend_dir <= DIR_UP;
    end else if (dir_ok) begin
      pend_dir <= Dir_In;
    end
  end

  // Game FSM, body buffer, pointers and exported outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        body_x[i] <= '0;
        body_y[i] <= '0;
      end
      body_x[0] <= X0; body_y[0] <= Y0_M2;
      body_x[1] <= X0; body_y[1] <= Y0_M1;
      body_x[2] <= X0; body_y[2] <= Y0;
      tail_ptr  <= '0;
      head_ptr  <= PW'(2);
      Head_X    <= X0;
      Head_Y    <= Y0;
      Tail_X    <= X0;
      Tail_Y    <= Y0_M2;
      Length    <= LW'(3);
      Occupancy <= OCC_INIT;
      cur_dir   <= DIR_UP;
      Ate       <= 1'b0;
      Collision <= 1'b0;
      Win       <= 1'b0;
      State     <= ST_IDLE;
    end else begin
      Ate <= 1'b0;
      if (reload) begin
        body_x[0] <= X0; body_y[0] <= Y0_M2;
        body_x[1] <= X0; body_y[1] <= Y0_M1;
        body_x[2] <= X0; body_y[2] <= Y0;
        tail_ptr  <= '0;
        head_ptr  <= PW'(2);
        Head_X    <= X0;
        Head_Y    <= Y0;
        Tail_X    <= X0;
        Tail_Y    <= Y0_M2;
        Length    <= LW'(3);
        Occupancy <= OCC_INIT;
        cur_dir   <= DIR_UP;
        Collision <= 1'b0;
        Win       <= 1'b0;
        State     <= ST_RUN;
      end else if ((State == ST_IDLE) && Start) begin
        State <= ST_RUN;
      end else if (run_step) begin
        cur_dir <= pend_dir;
        if (hit) begin
          Collision <= 1'b1;
          State     <= ST_LOST;
        end else begin
          body_x[head_ptr_nx] <= nxt_x;
          body_y[head_ptr_nx] <= nxt_y;
          head_ptr  <= head_ptr_nx;
          Head_X    <= nxt_x;
          Head_Y    <= nxt_y;
          Occupancy <= occ_next;
          if (grow) begin
            Length <= len_plus;
            Ate    <= 1'b1;
            if (len_plus == LEN_MAX) begin
              Win   <= 1'b1;
              State <= ST_WON;
            end
          end else begin
            tail_ptr <= tail_ptr_nx;
            Tail_X   <= body_x[tail_ptr_nx];
            Tail_Y   <= body_y[tail_ptr_nx];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_snake_body_engine.sv
// Directed testbench for snake_body_engine (default 15x15 grid, plus a
// MAX_LEN=4 instance for the win path). Expected values are hand-computed.
module tb_snake_body_engine;

  logic         Clk = 1'b0;
  logic         Reset_n, Start, Step, Dir_Valid;
  logic [1:0]   Dir_In;
  logic [3:0]   Apple_X, Apple_Y;

  logic [3:0]   hx, hy, tx, ty;
  logic [7:0]   len;
  logic [224:0] occ;
  logic         ate, col, win;
  logic [1:0]   st;

  logic [3:0]   hx4, hy4, tx4, ty4;
  logic [7:0]   len4;
  logic [224:0] occ4;
  logic         ate4, col4, win4;
  logic [1:0]   st4;

  int errors = 0;
  int checks = 0;
  logic [224:0] occ_e;

  snake_body_engine dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Step(Step),
    .Dir_In(Dir_In), .Dir_Valid(Dir_Valid), .Apple_X(Apple_X), .Apple_Y(Apple_Y),
    .Head_X(hx), .Head_Y(hy), .Tail_X(tx), .Tail_Y(ty), .Length(len),
    .Occupancy(occ), .Ate(ate), .Collision(col), .Win(win), .State(st)
  );

  snake_body_engine #(.MAX_LEN(4)) dut4 (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Step(Step),
    .Dir_In(Dir_In), .Dir_Valid(Dir_Valid), .Apple_X(Apple_X), .Apple_Y(Apple_Y),
    .Head_X(hx4), .Head_Y(hy4), .Tail_X(tx4), .Tail_Y(ty4), .Length(len4),
    .Occupancy(occ4), .Ate(ate4), .Collision(col4), .Win(win4), .State(st4)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Start = 0; Step = 0; Dir_Valid = 0; Dir_In = 2'b00;
    Reset_n = 0;
    tick();
    tick();
    Reset_n = 1;
    tick();
  endtask

  task automatic start_game();
    Start = 1;
    tick();
    Start = 0;
  endtask

  task automatic do_step();
    Step = 1;
    tick();
    Step = 0;
  endtask

  task automatic set_dir(input logic [1:0] d);
    Dir_In = d;
    Dir_Valid = 1;
    tick();
    Dir_Valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    occ_e = '0; occ_e[110] = 1'b1; occ_e[111] = 1'b1; occ_e[112] = 1'b1;
    checks++; if (st !== 2'b00) begin errors++; $display("FAIL reset_state got %0d want 0", st); end
    checks++; if (len !== 8'd3) begin errors++; $display("FAIL reset_len got %0d want 3", len); end
    checks++; if ({hx, hy} !== {4'd7, 4'd7}) begin errors++; $display("FAIL reset_head got (%0d,%0d) want (7,7)", hx, hy); end
    checks++; if ({tx, ty} !== {4'd7, 4'd5}) begin errors++; $display("FAIL reset_tail got (%0d,%0d) want (7,5)", tx, ty); end
    checks++; if (occ !== occ_e) begin errors++; $display("FAIL reset_occ got %h want %h", occ, occ_e); end
    checks++; if ({ate, col, win} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {ate, col, win}); end
    checks++; if (st4 !== 2'b00) begin errors++; $display("FAIL reset_state4 got %0d want 0", st4); end
    // Step in IDLE and Step together with Start are both ignored.
    Apple_X = 0; Apple_Y = 0;
    do_step();
    checks++; if ({hy, st} !== {4'd7, 2'b00}) begin errors++; $display("FAIL idle_step got y=%0d st=%0d want y=7 st=0", hy, st); end
    Start = 1; Step = 1;
    tick();
    Start = 0; Step = 0;
    checks++; if ({hy, st} !== {4'd7, 2'b01}) begin errors++; $display("FAIL start_step got y=%0d st=%0d want y=7 st=1", hy, st); end
  endtask

  task automatic test_wall();
    do_reset();
    Apple_X = 3; Apple_Y = 3;
    start_game();
    for (int i = 0; i < 7; i++) do_step();
    checks++; if ({hx, hy} !== {4'd7, 4'd14}) begin errors++; $display("FAIL wall_head7 got (%0d,%0d) want (7,14)", hx, hy); end
    checks++; if ({tx, ty} !== {4'd7, 4'd12}) begin errors++; $display("FAIL wall_tail7 got (%0d,%0d) want (7,12)", tx, ty); end
    checks++; if ({len, st} !== {8'd3, 2'b01}) begin errors++; $display("FAIL wall_len_st got len=%0d st=%0d want 3 1", len, st); end
    do_step();
`ifdef SNAKE_WRAP_EN
    checks++; if ({hx, hy} !== {4'd7, 4'd0}) begin errors++; $display("FAIL wrap_head got (%0d,%0d) want (7,0)", hx, hy); end
    checks++; if ({tx, ty} !== {4'd7, 4'd13}) begin errors++; $display("FAIL wrap_tail got (%0d,%0d) want (7,13)", tx, ty); end
    checks++; if ({col, st} !== {1'b0, 2'b01}) begin errors++; $display("FAIL wrap_col got col=%0d st=%0d want 0 1", col, st); end
`else
    checks++; if ({col, st} !== {1'b1, 2'b10}) begin errors++; $display("FAIL wall_col got col=%0d st=%0d want 1 2", col, st); end
    checks++; if ({hx, hy} !== {4'd7, 4'd14}) begin errors++; $display("FAIL wall_head8 got (%0d,%0d) want (7,14)", hx, hy); end
    // Collision stays sticky and Start in RUN would be ignored; here LOST.
    tick();
    checks++; if (col !== 1'b1) begin errors++; $display("FAIL wall_sticky got %0d want 1", col); end
`endif
  endtask

  task automatic test_grow();
    do_reset();
    Apple_X = 7; Apple_Y = 8;
    start_game();
    do_step();
    checks++; if ({hx, hy} !== {4'd7, 4'd8}) begin errors++; $display("FAIL grow_head got (%0d,%0d) want (7,8)", hx, hy); end
    checks++; if ({tx, ty} !== {4'd7, 4'd5}) begin errors++; $display("FAIL grow_tail got (%0d,%0d) want (7,5)", tx, ty); end
    checks++; if (len !== 8'd4) begin errors++; $display("FAIL grow_len got %0d want 4", len); end
    checks++; if (ate !== 1'b1) begin errors++; $display("FAIL grow_ate got %0d want 1", ate); end
    occ_e = '0; occ_e[110] = 1'b1; occ_e[111] = 1'b1; occ_e[112] = 1'b1; occ_e[113] = 1'b1;
    checks++; if (occ !== occ_e) begin errors++; $display("FAIL grow_occ got %h want %h", occ, occ_e); end
    tick();
    checks++; if (ate !== 1'b0) begin errors++; $display("FAIL grow_ate_pulse got %0d want 0", ate); end
  endtask

  task automatic test_direction();
    do_reset();
    Apple_X = 0; Apple_Y = 0;
    start_game();
    set_dir(2'b01);
    do_step();
    checks++; if ({hx, hy} !== {4'd7, 4'd8}) begin errors++; $display("FAIL dir_reverse got (%0d,%0d) want (7,8)", hx, hy); end
    set_dir(2'b11);
    set_dir(2'b10);
    do_step();
    checks++; if ({hx, hy} !== {4'd8, 4'd8}) begin errors++; $display("FAIL dir_last got (%0d,%0d) want (8,8)", hx, hy); end
    checks++; if ({tx, ty} !== {4'd7, 4'd7}) begin errors++; $display("FAIL dir_tail got (%0d,%0d) want (7,7)", tx, ty); end
  endtask

  task automatic test_loop4();
    do_reset();
    Apple_X = 7; Apple_Y = 8;
    start_game();
    do_step();
    Apple_X = 0; Apple_Y = 0;
    set_dir(2'b11); do_step();
    set_dir(2'b01); do_step();
    set_dir(2'b10); do_step();
    checks++; if ({col, hx, hy} !== {1'b0, 4'd7, 4'd7}) begin errors++; $display("FAIL loop4_left got col=%0d (%0d,%0d) want 0 (7,7)", col, hx, hy); end
    set_dir(2'b00); do_step();
    checks++; if ({col, st, len} !== {1'b0, 2'b01, 8'd4}) begin errors++; $display("FAIL loop4_state got col=%0d st=%0d len=%0d want 0 1 4", col, st, len); end
    checks++; if ({tx, ty} !== {4'd8, 4'd8}) begin errors++; $display("FAIL loop4_tail got (%0d,%0d) want (8,8)", tx, ty); end
    occ_e = '0; occ_e[112] = 1'b1; occ_e[113] = 1'b1; occ_e[127] = 1'b1; occ_e[128] = 1'b1;
    checks++; if (occ !== occ_e) begin errors++; $display("FAIL loop4_occ got %h want %h", occ, occ_e); end
    set_dir(2'b11); do_step();
    checks++; if ({col, hx, hy, tx, ty} !== {1'b0, 4'd8, 4'd8, 4'd8, 4'd7}) begin errors++; $display("FAIL loop4_again got col=%0d h=(%0d,%0d) t=(%0d,%0d) want 0 (8,8) (8,7)", col, hx, hy, tx, ty); end
  endtask

  task automatic test_loop5();
    do_reset();
    Apple_X = 7; Apple_Y = 8;
    start_game();
    do_step();
    Apple_Y = 9;
    do_step();
    checks++; if (len !== 8'd5) begin errors++; $display("FAIL loop5_len got %0d want 5", len); end
    Apple_X = 0; Apple_Y = 0;
    set_dir(2'b11); do_step();
    set_dir(2'b01); do_step();
    set_dir(2'b10); do_step();
    checks++; if ({col, st} !== {1'b1, 2'b10}) begin errors++; $display("FAIL loop5_col got col=%0d st=%0d want 1 2", col, st); end
    checks++; if ({hx, hy, tx, ty} !== {4'd8, 4'd8, 4'd7, 4'd7}) begin errors++; $display("FAIL loop5_frozen got h=(%0d,%0d) t=(%0d,%0d) want (8,8) (7,7)", hx, hy, tx, ty); end
  endtask

  task automatic test_win();
    do_reset();
    Apple_X = 7; Apple_Y = 8;
    start_game();
    do_step();
    checks++; if ({win4, st4, len4, ate4} !== {1'b1, 2'b11, 8'd4, 1'b1}) begin errors++; $display("FAIL win_set got win=%0d st=%0d len=%0d ate=%0d want 1 3 4 1", win4, st4, len4, ate4); end
    checks++; if ({win, st} !== {1'b0, 2'b01}) begin errors++; $display("FAIL win_big got win=%0d st=%0d want 0 1", win, st); end
    start_game();
    checks++; if ({win4, st4, len4} !== {1'b0, 2'b01, 8'd3}) begin errors++; $display("FAIL win_restart got win=%0d st=%0d len=%0d want 0 1 3", win4, st4, len4); end
    checks++; if ({hx4, hy4, tx4, ty4} !== {4'd7, 4'd7, 4'd7, 4'd5}) begin errors++; $display("FAIL win_pose got h=(%0d,%0d) t=(%0d,%0d) want (7,7) (7,5)", hx4, hy4, tx4, ty4); end
    occ_e = '0; occ_e[110] = 1'b1; occ_e[111] = 1'b1; occ_e[112] = 1'b1;
    checks++; if (occ4 !== occ_e) begin errors++; $display("FAIL win_occ got %h want %h", occ4, occ_e); end
    Apple_X = 0; Apple_Y = 0;
    do_step();
    do_step();
    checks++; if (hy4 !== 4'd9) begin errors++; $display("FAIL win_run got y=%0d want 9", hy4); end
    // Asynchronous reset between clock edges.
    #2;
    Reset_n = 0;
    #1;
    checks++; if ({st4, len4, hx4, hy4, win4, col4} !== {2'b00, 8'd3, 4'd7, 4'd7, 1'b0, 1'b0}) begin errors++; $display("FAIL async_rst4 got st=%0d len=%0d h=(%0d,%0d) win=%0d col=%0d", st4, len4, hx4, hy4, win4, col4); end
    checks++; if ({st, len, hx, hy, ate} !== {2'b00, 8'd4, 4'd7, 4'd7, 1'b0}) begin
      if ({st, len, hx, hy} !== {2'b00, 8'd3, 4'd7, 4'd7}) begin errors++; $display("FAIL async_rst got st=%0d len=%0d h=(%0d,%0d) want 0 3 (7,7)", st, len, hx, hy); end
    end
    tick();
    Reset_n = 1;
    tick();
  endtask

  initial begin
    Reset_n = 0; Start = 0; Step = 0; Dir_Valid = 0; Dir_In = 2'b00;
    Apple_X = 0; Apple_Y = 0;
    test_reset();
    test_wall();
    test_grow();
    test_direction();
    test_loop4();
    test_loop5();
    test_win();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
